// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU input loader slice.
package npu_pkg;

  localparam int unsigned NPU_BYTE_W = 8;
  localparam int unsigned LANE_W     = 2;

  localparam logic [LANE_W-1:0] LANE_A = 2'd0;
  localparam logic [LANE_W-1:0] LANE_B = 2'd1;
  localparam logic [LANE_W-1:0] LANE_C = 2'd2;
  localparam logic [LANE_W-1:0] LANE_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    LOAD     = 3'd2,
    WAIT_ACK = 3'd3,
    FIN      = 3'd4
  } npu_state_e;

  // Four-lane vector as presented to the input buffer data pins.
  typedef struct packed {
    logic [NPU_BYTE_W-1:0] d;
    logic [NPU_BYTE_W-1:0] c;
    logic [NPU_BYTE_W-1:0] b;
    logic [NPU_BYTE_W-1:0] a;
  } npu_vec_t;

endpackage

// File: rtl/npu_lane_assembler.sv
// Lane counter plus the four staged lane registers; bytes land in A..D order.
module npu_lane_assembler
  import npu_pkg::*;
(
  input  logic                  CLKEXT,
  input  logic                  CLR_BUF_IN,
  input  logic                  wr_en,
  input  logic                  clr_idx,
  input  logic [NPU_BYTE_W-1:0] data,
  output logic [LANE_W-1:0]     lane,
  output npu_vec_t              lanes
);

  // Lane index wraps 3 -> 0 naturally; lanes keep their value until rewritten.
  always_ff @(posedge CLKEXT or negedge CLR_BUF_IN) begin
    if (!CLR_BUF_IN) begin
      lane  <= LANE_A;
      lanes <= '0;
    end else begin
      if (clr_idx) begin
        lane <= LANE_A;
      end else if (wr_en) begin
        lane <= lane + LANE_W'(1);
      end
      if (wr_en) begin
        case (lane)
          LANE_A: lanes.a <= data;
          LANE_B: lanes.b <= data;
          LANE_C: lanes.c <= data;
          LANE_D: lanes.d <= data;
        endcase
      end
    end
  end

endmodule

// File: rtl/npu_input_loader.sv
// Byte-stream to NPU input buffer sequencer: assemble, load, present, repeat per batch.
module npu_input_loader
  import npu_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned IW          = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                  CLKEXT,
  input  logic                  CLR_BUF_IN,
  input  logic                  START,
  input  logic [NPU_BYTE_W-1:0] S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  output logic [NPU_BYTE_W-1:0] DA,
  output logic [NPU_BYTE_W-1:0] DB,
  output logic [NPU_BYTE_W-1:0] DC,
  output logic [NPU_BYTE_W-1:0] DD,
  output logic                  EN_BUF_IN,
  output logic                  VEC_VALID,
  input  logic                  VEC_ACK,
  output logic [IW-1:0]         VEC_IDX,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [IW-1:0] LAST_VEC = IW'(NUM_VECTORS - 1);

  npu_state_e          state_q, state_nxt;
  logic [IW-1:0]       vec_q, vec_nxt;
  logic                wr_en, clr_idx;
  logic [LANE_W-1:0]   lane;
  npu_vec_t            lanes;

  npu_lane_assembler u_lanes (
    .CLKEXT     (CLKEXT),
    .CLR_BUF_IN (CLR_BUF_IN),
    .wr_en      (wr_en),
    .clr_idx    (clr_idx),
    .data       (S_DATA),
    .lane       (lane),
    .lanes      (lanes)
  );

  always_ff @(posedge CLKEXT or negedge CLR_BUF_IN) begin
    if (!CLR_BUF_IN) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_nxt;
      vec_q   <= vec_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    vec_nxt   = vec_q;
    wr_en     = 1'b0;
    clr_idx   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          clr_idx   = 1'b1;
          vec_nxt   = '0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (S_VALID) begin
          wr_en = 1'b1;
          if (lane == LANE_D) state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (VEC_ACK) begin
          if (vec_q == LAST_VEC) begin
            state_nxt = FIN;
          end else begin
            vec_nxt   = vec_q + IW'(1);
            state_nxt = FILL;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are registered decodes of the next state, so they track the state exactly.
  always_ff @(posedge CLKEXT or negedge CLR_BUF_IN) begin
    if (!CLR_BUF_IN) begin
      S_READY   <= 1'b0;
      EN_BUF_IN <= 1'b0;
      VEC_VALID <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      S_READY   <= (state_nxt == FILL);
      EN_BUF_IN <= (state_nxt == LOAD);
      VEC_VALID <= (state_nxt == WAIT_ACK);
      BUSY      <= (state_nxt != IDLE);
      DONE      <= (state_nxt == FIN);
    end
  end

  assign VEC_IDX = vec_q;
  assign DA      = lanes.a;
  assign DB      = lanes.b;
  assign DC      = lanes.c;
  assign DD      = lanes.d;

endmodule
